// File: rtl/bus_sequencer_if.sv
// Handshake and datapath-control bundle for bus_sequencer.
// The master side issues run/instr; the slave side (the sequencer) drives the control outputs.
interface bus_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             run;
    logic [5:0]       instr;
    logic [1:0]       bus_sel;
    logic [1:0]       reg_sel;
    logic [3:0]       rin;
    logic             ain;
    logic             gin;
    logic             addsub;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] icount;

    modport master (
        output run, instr,
        input  bus_sel, reg_sel, rin, ain, gin, addsub, busy, done, icount
    );

    modport slave (
        input  run, instr,
        output bus_sel, reg_sel, rin, ain, gin, addsub, busy, done, icount
    );
endinterface

// File: rtl/bus_sequencer.sv
// Multi-cycle control sequencer for a 4-register datapath: mv/mvi finish in T1,
// add/sub walk T1 (load A), T2 (load G), T3 (write back).
module bus_sequencer #(
    parameter int unsigned CNT_W = 8
) (
    input logic            clock,
    input logic            reset,
    bus_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_e;

    localparam logic [1:0] OpMv  = 2'b00;
    localparam logic [1:0] OpMvi = 2'b01;

    state_e           state_q, state_d;
    logic [5:0]       ir_q, ir_d;
    logic [CNT_W-1:0] icount_q, icount_d;

    logic [1:0] op, rx, ry;
    logic [3:0] rx_onehot;

    logic [1:0] bus_sel;
    logic [1:0] reg_sel;
    logic [3:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;

    assign op        = ir_q[5:4];
    assign rx        = ir_q[3:2];
    assign ry        = ir_q[1:0];
    assign rx_onehot = 4'b0001 << rx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            ir_q     <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            icount_q <= icount_d;
        end
    end

    // Outputs depend only on state_q and ir_q, so run/instr never reach them combinationally.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        icount_d = icount_q;
        bus_sel  = 2'b11;
        reg_sel  = 2'b00;
        rin      = 4'b0000;
        ain      = 1'b0;
        gin      = 1'b0;
        addsub   = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.run) begin
                    ir_d    = bus.instr;
                    state_d = StT1;
                end
            end
            StT1: begin
                if (op == OpMv) begin
                    bus_sel = 2'b00;
                    reg_sel = ry;
                    rin     = rx_onehot;
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (op == OpMvi) begin
                    bus_sel = 2'b01;
                    rin     = rx_onehot;
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    bus_sel = 2'b00;
                    reg_sel = rx;
                    ain     = 1'b1;
                    state_d = StT2;
                end
            end
            StT2: begin
                bus_sel = 2'b00;
                reg_sel = ry;
                gin     = 1'b1;
                addsub  = op[0];
                state_d = StT3;
            end
            StT3: begin
                bus_sel = 2'b10;
                rin     = rx_onehot;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (done) begin
            icount_d = icount_q + CNT_W'(1);
        end
    end

    assign bus.bus_sel = bus_sel;
    assign bus.reg_sel = reg_sel;
    assign bus.rin     = rin;
    assign bus.ain     = ain;
    assign bus.gin     = gin;
    assign bus.addsub  = addsub;
    assign bus.done    = done;
    assign bus.busy    = (state_q != StIdle);
    assign bus.icount  = icount_q;
endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed literal checks plus randomized traffic against a
// queue-of-expected-cycles model, run on an 8-bit and a 2-bit counter instance in parallel.
module tb_bus_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run   = 1'b0;
    logic [5:0] instr = 6'd0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    bus_sequencer_if #(.CNT_W(8)) if8 ();
    bus_sequencer_if #(.CNT_W(2)) if2 ();

    assign if8.run   = run;
    assign if8.instr = instr;
    assign if2.run   = run;
    assign if2.instr = instr;

    bus_sequencer #(.CNT_W(8)) dut8 (.clock(clock), .reset(reset), .bus(if8));
    bus_sequencer #(.CNT_W(2)) dut2 (.clock(clock), .reset(reset), .bus(if2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One expected output cycle: {bus_sel, reg_sel, rin, ain, gin, addsub, done}
    typedef struct packed {
        logic [1:0] bus_sel;
        logic [1:0] reg_sel;
        logic [3:0] rin;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       done;
    } cyc_t;

    localparam cyc_t IdleCyc = '{bus_sel: 2'b11, reg_sel: 2'b00, rin: 4'b0000,
                                 ain: 1'b0, gin: 1'b0, addsub: 1'b0, done: 1'b0};

    cyc_t m_q[$];
    int   m_cnt   = 0;
    bit   m_valid = 1'b0;

    function automatic void push_instr(input logic [5:0] i);
        logic [1:0] op, rx, ry;
        logic [3:0] oh;
        cyc_t c;
        op = i[5:4];
        rx = i[3:2];
        ry = i[1:0];
        oh = 4'b0001 << rx;
        c  = IdleCyc;
        case (op)
            2'b00: begin
                c.bus_sel = 2'b00; c.reg_sel = ry; c.rin = oh; c.done = 1'b1;
                m_q.push_back(c);
            end
            2'b01: begin
                c.bus_sel = 2'b01; c.rin = oh; c.done = 1'b1;
                m_q.push_back(c);
            end
            default: begin
                c.bus_sel = 2'b00; c.reg_sel = rx; c.ain = 1'b1;
                m_q.push_back(c);
                c = IdleCyc;
                c.bus_sel = 2'b00; c.reg_sel = ry; c.gin = 1'b1; c.addsub = op[0];
                m_q.push_back(c);
                c = IdleCyc;
                c.bus_sel = 2'b10; c.rin = oh; c.done = 1'b1;
                m_q.push_back(c);
            end
        endcase
    endfunction

    function automatic cyc_t dut_cyc8();
        cyc_t c;
        c = '{bus_sel: if8.bus_sel, reg_sel: if8.reg_sel, rin: if8.rin, ain: if8.ain,
              gin: if8.gin, addsub: if8.addsub, done: if8.done};
        return c;
    endfunction

    function automatic cyc_t dut_cyc2();
        cyc_t c;
        c = '{bus_sel: if2.bus_sel, reg_sel: if2.reg_sel, rin: if2.rin, ain: if2.ain,
              gin: if2.gin, addsub: if2.addsub, done: if2.done};
        return c;
    endfunction

    // Model advance on each rising edge, then compare shortly after.
    always @(posedge clock) begin
        cyc_t exp_c;
        if (reset) begin
            m_q.delete();
            m_cnt   = 0;
            m_valid = 1'b1;
        end else if (m_q.size() != 0) begin
            if (m_q[0].done) m_cnt++;
            void'(m_q.pop_front());
        end else if (run) begin
            push_instr(instr);
        end
        #2;
        if (m_valid) begin
            exp_c = (m_q.size() != 0) ? m_q[0] : IdleCyc;
            check("outs8", 32'(dut_cyc8()), 32'(exp_c));
            check("outs2", 32'(dut_cyc2()), 32'(exp_c));
            check("busy8", 32'(if8.busy), 32'(m_q.size() != 0));
            check("icount8", 32'(if8.icount), 32'(m_cnt % 256));
            check("icount2", 32'(if2.icount), 32'(m_cnt % 4));
        end
    end

    task automatic nedge();
        @(negedge clock);
    endtask

    initial begin
        logic [1:0] seq2 [5];
        seq2[0] = 2'd1; seq2[1] = 2'd2; seq2[2] = 2'd3; seq2[3] = 2'd0; seq2[4] = 2'd1;

        reset = 1'b1;
        nedge(); nedge();
        reset = 1'b0;
        check("rst_bus_sel", 32'(if8.bus_sel), 32'h3);
        check("rst_busy", 32'(if8.busy), 32'h0);
        check("rst_icount", 32'(if8.icount), 32'h0);

        // mv R2,R1
        run = 1'b1; instr = 6'b00_10_01;
        nedge(); run = 1'b0;
        check("mv_bus_sel", 32'(if8.bus_sel), 32'h0);
        check("mv_reg_sel", 32'(if8.reg_sel), 32'h1);
        check("mv_rin", 32'(if8.rin), 32'h4);
        check("mv_done", 32'(if8.done), 32'h1);
        nedge();
        check("mv_idle", 32'(if8.busy), 32'h0);
        check("mv_icount", 32'(if8.icount), 32'h1);

        // mvi R3
        run = 1'b1; instr = 6'b01_11_00;
        nedge(); run = 1'b0;
        check("mvi_bus_sel", 32'(if8.bus_sel), 32'h1);
        check("mvi_rin", 32'(if8.rin), 32'h8);
        check("mvi_done", 32'(if8.done), 32'h1);
        nedge();

        // sub R0,R2
        run = 1'b1; instr = 6'b11_00_10;
        nedge(); run = 1'b0;
        check("sub_t1", 32'({if8.bus_sel, if8.reg_sel, if8.ain, if8.done}), 32'b00_00_1_0);
        nedge();
        check("sub_t2", 32'({if8.reg_sel, if8.gin, if8.addsub, if8.rin}), 32'b10_1_1_0000);
        nedge();
        check("sub_t3", 32'({if8.bus_sel, if8.rin, if8.done}), 32'b10_0001_1);
        nedge();
        check("sub_icount", 32'(if8.icount), 32'h3);

        // add R1,R3 with run/instr toggled during T2
        run = 1'b1; instr = 6'b10_01_11;
        nedge(); run = 1'b0;
        nedge();
        run = 1'b1; instr = 6'b00_00_00;
        check("add_t2", 32'({if8.reg_sel, if8.gin, if8.addsub}), 32'b11_1_0);
        nedge();
        check("add_t3", 32'({if8.bus_sel, if8.rin, if8.done}), 32'b10_0010_1);
        nedge();
        check("add_gap_busy", 32'(if8.busy), 32'h0);
        check("add_icount", 32'(if8.icount), 32'h4);
        nedge(); run = 1'b0;
        check("late_run_mv", 32'({if8.rin, if8.done}), 32'b0001_1);
        nedge();

        // reset during T2 of an add
        run = 1'b1; instr = 6'b10_00_01;
        nedge(); run = 1'b0;
        nedge(); reset = 1'b1;
        nedge(); reset = 1'b0;
        check("abort_outs", 32'({if8.busy, if8.rin, if8.ain, if8.gin, if8.done}), 32'h0);
        check("abort_icount", 32'(if8.icount), 32'h0);
        check("abort_icount2", 32'(if2.icount), 32'h0);

        // 2-bit counter wrap
        for (int k = 0; k < 5; k++) begin
            run = 1'b1; instr = 6'b00_01_10;
            nedge(); run = 1'b0;
            nedge();
            check("wrap_icount2", 32'(if2.icount), 32'(seq2[k]));
        end

        // randomized traffic, checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            run   = ($urandom_range(0, 1) == 1);
            instr = 6'($urandom_range(0, 63));
            reset = ($urandom_range(0, 63) == 0);
            nedge();
        end
        reset = 1'b0; run = 1'b0;
        nedge(); nedge(); nedge(); nedge();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
